key_debounce_sched: RTL

//  Scheduler that time-shares ONE debounce timer among N_KEYS push-buttons.
//  The per-key counters are replaced by a round-robin arbiter and a single FSM-driven counter.
//  It emits one press event per debounced press through a valid/ready handshake.
//  It also advances a per-key 2-bit mode counter that drives one LED per key.
//  It sits between the board keys and the LED/user logic of the key-LED design.

---
 rtl/key_debounce_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/key_debounce_sched.sv
// rtl/key_debounce_sched.sv - one shared debounce timer time-multiplexed over N_KEYS buttons
// Confirmed presses become valid/ready events and step a per-key 2-bit LED mode counter.
module key_debounce_sched #(
  parameter int N_KEYS    = 4,
  parameter int DB_CYCLES = 50_000_000,
  localparam int CNT_W    = $clog2(DB_CYCLES),
  localparam int ID_W     = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic [N_KEYS-1:0] led,
  output logic              busy
);

  typedef enum logic [1:0] {SCAN = 2'd0, SETTLE = 2'd1, REPORT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [N_KEYS-1:0]       sync_meta_q, sync_meta_d;
  logic [N_KEYS-1:0]       ks_q, ks_d;
  logic [N_KEYS-1:0]       held_q, held_d;
  logic [N_KEYS-1:0]       led_q, led_d;
  logic [N_KEYS-1:0][1:0]  mode_q, mode_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         owner_q, owner_d;
  logic                    target_q, target_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    evt_valid_q, evt_valid_d;

  logic [N_KEYS-1:0]       cand;
  logic                    found;
  logic [ID_W-1:0]         grant;

  // off is always < N_KEYS, so a single conditional subtract wraps correctly.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_KEYS) s = s - N_KEYS;
    return ID_W'(s);
  endfunction

  // Press candidate: not held and low. Release candidate: held and high.
  assign cand = ~(held_q ^ ks_q);

  always_comb begin
    found = 1'b0;
    grant = ptr_q;
    for (int k = 0; k < N_KEYS; k++) begin
      if (!found && cand[wrap_add(ptr_q, k)]) begin
        found = 1'b1;
        grant = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_meta_d = key;
    ks_d        = sync_meta_q;
    held_d      = held_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    evt_valid_d = 1'b0;
    for (int i = 0; i < N_KEYS; i++) led_d[i] = mode_q[i][1] ^ mode_q[i][0];

    case (state_q)
      SCAN: begin
        if (found) begin
          owner_d  = grant;
          target_d = held_q[grant];
          cnt_d    = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (ks_q[owner_q] != target_q) begin
          ptr_d   = wrap_add(owner_q, 1);
          state_d = SCAN;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!target_q) begin
          held_d[owner_q] = 1'b1;
          mode_d[owner_q] = mode_q[owner_q] + 2'd1;
          state_d         = REPORT;
        end else begin
          held_d[owner_q] = 1'b0;
          ptr_d           = wrap_add(owner_q, 1);
          state_d         = SCAN;
        end
      end
      REPORT: begin
        // evt_valid is registered, so it rises one cycle after entry, in step with led.
        if (evt_valid_q && evt_ready) begin
          ptr_d   = wrap_add(owner_q, 1);
          state_d = SCAN;
        end else begin
          evt_valid_d = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      sync_meta_q <= '1;
      ks_q        <= '1;
      held_q      <= '0;
      led_q       <= '0;
      mode_q      <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      target_q    <= 1'b0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_meta_q <= sync_meta_d;
      ks_q        <= ks_d;
      held_q      <= held_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = owner_q;
  assign led       = led_q;
  assign busy      = (state_q != SCAN);

endmodule
